// File: rtl/muldiv_sched.sv
// Sequencer for the shared HI/LO resource: starts Mult or Div, waits for its completion
// flag (with a cycle budget), then writes HI/LO and reports the outcome to Controle.
module muldiv_sched #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_start,
    input  logic [1:0]       op_sel,
    input  logic [31:0]      divisor,
    input  logic             mult_done,
    input  logic             div_done,
    output logic             MultCtrl,
    output logic             DivCtrl,
    output logic             HICtrl,
    output logic             LOCtrl,
    output logic             WriteHI,
    output logic             WriteLO,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             timeout,
    output logic [CNT_W-1:0] wait_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ZERO  = 3'd5,
        FAULT = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_t           stateQ;
    state_t           stateNext;
    logic             opDiv;
    logic             muxSel;
    logic [CNT_W-1:0] waitCnt;
    logic             unitDone;

    // Only the unit that was actually started may end the wait.
    assign unitDone = opDiv ? div_done : mult_done;
    assign wait_cnt = waitCnt;
    assign HICtrl   = muxSel;
    assign LOCtrl   = muxSel;

    always_comb begin
        stateNext = stateQ;
        MultCtrl  = 1'b0;
        DivCtrl   = 1'b0;
        WriteHI   = 1'b0;
        WriteLO   = 1'b0;
        done      = 1'b0;
        div_zero  = 1'b0;
        timeout   = 1'b0;
        busy      = (stateQ != IDLE);
        case (stateQ)
            IDLE: begin
                if (op_start) begin
                    if (op_sel[1])
                        stateNext = DONE;
                    else if (op_sel[0] && (divisor == 32'd0))
                        stateNext = ZERO;
                    else
                        stateNext = START;
                end
            end
            START: begin
                MultCtrl  = ~opDiv;
                DivCtrl   = opDiv;
                stateNext = WAIT;
            end
            WAIT: begin
                if (unitDone)
                    stateNext = WRITE;
                else if (waitCnt == LAST_CNT)
                    stateNext = FAULT;
            end
            WRITE: begin
                WriteHI   = 1'b1;
                WriteLO   = 1'b1;
                stateNext = DONE;
            end
            DONE: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            ZERO: begin
                div_zero  = 1'b1;
                done      = 1'b1;
                stateNext = IDLE;
            end
            FAULT: begin
                timeout   = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateQ  <= IDLE;
            opDiv   <= 1'b0;
            muxSel  <= 1'b0;
            waitCnt <= '0;
        end else begin
            stateQ <= stateNext;
            if (stateQ == IDLE && op_start && !op_sel[1]) begin
                opDiv <= op_sel[0];
                // Mux select moves only when a unit is really going to be started,
                // so it is settled well before the write cycle.
                if (stateNext == START)
                    muxSel <= ~op_sel[0];
            end
            if (stateQ == START)
                waitCnt <= '0;
            else if (stateQ == WAIT && !unitDone && waitCnt != LAST_CNT)
                waitCnt <= waitCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_muldiv_sched.sv
// Randomized scoreboard bench for muldiv_sched: a driver pushes outcome predictions,
// a monitor pops and compares them whenever the block signals completion.
module tb_muldiv_sched;

    localparam int TIMEOUT = 40;
    localparam int CNT_W   = 6;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             op_start = 1'b0;
    logic [1:0]       op_sel = 2'b00;
    logic [31:0]      divisor = 32'd0;
    logic             mult_done = 1'b0;
    logic             div_done = 1'b0;
    logic             MultCtrl, DivCtrl, HICtrl, LOCtrl, WriteHI, WriteLO;
    logic             busy, done, div_zero, timeout;
    logic [CNT_W-1:0] wait_cnt;

    muldiv_sched #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .op_start(op_start), .op_sel(op_sel),
        .divisor(divisor), .mult_done(mult_done), .div_done(div_done),
        .MultCtrl(MultCtrl), .DivCtrl(DivCtrl), .HICtrl(HICtrl), .LOCtrl(LOCtrl),
        .WriteHI(WriteHI), .WriteLO(WriteLO), .busy(busy), .done(done),
        .div_zero(div_zero), .timeout(timeout), .wait_cnt(wait_cnt)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] flags;   // {done, div_zero, timeout}
        int         lat;     // cycles from the op_start cycle to the terminal pulse
        int         mults;
        int         divs;
        int         writes;
        logic       hiChk;
        logic       hi;
        int         issue;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Outcome predicted from the operation's rules. The op_start cycle counts as
    // cycle 1, so "done at 4+k" is 3+k cycles after it, and 2-cycle paths are 1 after.
    function automatic exp_t model(input logic [1:0] sel, input logic [31:0] dv,
                                   input int d, input int issue);
        exp_t e;
        e.issue = issue; e.hiChk = 1'b0; e.hi = 1'b0;
        e.mults = 0; e.divs = 0; e.writes = 0;
        if (sel[1]) begin
            e.flags = 3'b100; e.lat = 1;
        end else if (sel == 2'b01 && dv == 32'd0) begin
            e.flags = 3'b110; e.lat = 1;
        end else begin
            e.mults = (sel == 2'b00) ? 1 : 0;
            e.divs  = (sel == 2'b01) ? 1 : 0;
            if (d <= TIMEOUT) begin
                e.flags = 3'b100; e.lat = d + 3; e.writes = 1;
                e.hiChk = 1'b1; e.hi = (sel == 2'b00);
            end else begin
                e.flags = 3'b001; e.lat = TIMEOUT + 2;
            end
        end
        return e;
    endfunction

    // Monitor
    int   mMults = 0, mDivs = 0, mWrites = 0;
    logic mHi = 1'b0, mLo = 1'b0;
    logic expectIdle = 1'b0;
    exp_t me;

    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                mMults = 0; mDivs = 0; mWrites = 0; expectIdle = 1'b0;
            end else begin
                if (MultCtrl || DivCtrl) check("one_start_pulse", MultCtrl & DivCtrl, 0);
                if (WriteHI || WriteLO) check("write_pair", WriteHI, WriteLO);
                mMults += int'(MultCtrl);
                mDivs  += int'(DivCtrl);
                if (WriteHI) begin
                    mWrites++; mHi = HICtrl; mLo = LOCtrl;
                end
                if (expectIdle) begin
                    check("busy_after_done", busy, 0);
                    expectIdle = 1'b0;
                end
                if (done || div_zero || timeout) begin
                    if (expQ.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_end: got flags %b expected none (cycle %0d)",
                                 {done, div_zero, timeout}, cyc);
                    end else begin
                        me = expQ.pop_front();
                        check("end_flags", {done, div_zero, timeout}, me.flags);
                        check("latency", cyc - me.issue, me.lat);
                        check("mult_pulses", mMults, me.mults);
                        check("div_pulses", mDivs, me.divs);
                        check("write_cycles", mWrites, me.writes);
                        if (me.hiChk) begin
                            check("hi_sel", mHi, me.hi);
                            check("lo_sel", mLo, me.hi);
                        end
                    end
                    expectIdle = 1'b1;
                    mMults = 0; mDivs = 0; mWrites = 0;
                end
            end
        end
    end

    // Driver: always resumes 1 time unit after a rising edge.
    task automatic runOp(input logic [1:0] sel, input logic [31:0] dv, input int d,
                         input bit spurious);
        int n = 0;
        int last;
        while (busy) begin
            @(posedge clock); #1;
            n++;
            if (n > 200) begin
                $display("FAIL idle_wait: got busy=1 expected busy=0 within 200 cycles");
                $fatal(1, "stuck busy");
            end
        end
        op_start = 1'b1; op_sel = sel; divisor = dv;
        expQ.push_back(model(sel, dv, d, cyc));
        @(posedge clock); #1;
        op_start = 1'b0; op_sel = 2'($urandom); divisor = $urandom;
        if (!sel[1] && !(sel == 2'b01 && dv == 32'd0)) begin
            last = (d <= TIMEOUT) ? d : TIMEOUT;
            for (int j = 1; j <= last; j++) begin
                @(posedge clock); #1;
                mult_done = (sel == 2'b00) ? (j == d) : (spurious && ($urandom % 3 == 0));
                div_done  = (sel == 2'b01) ? (j == d) : (spurious && ($urandom % 3 == 0));
                op_start  = spurious && ((j == 2) || ($urandom % 6 == 0));
            end
            @(posedge clock); #1;
            mult_done = 1'b0; div_done = 1'b0; op_start = 1'b0;
            if (d <= TIMEOUT) begin
                check("write_wait_cnt", wait_cnt, d - 1);
            end else begin
                check("fault_wait_cnt", wait_cnt, TIMEOUT - 1);
                check("fault_pulse", timeout, 1);
            end
        end
    endtask

    initial begin
        int stray;
        repeat (3) @(posedge clock);
        #1;
        check("rst_strobes", {MultCtrl, DivCtrl, WriteHI, WriteLO, done, div_zero, timeout}, 0);
        check("rst_busy", busy, 0);
        check("rst_mux", {HICtrl, LOCtrl}, 0);
        check("rst_wait_cnt", wait_cnt, 0);
        @(posedge clock); #1;
        reset = 1'b1;

        // MULT aborted by reset during its third WAIT cycle.
        @(posedge clock); #1;
        op_start = 1'b1; op_sel = 2'b00;
        @(posedge clock); #1;
        op_start = 1'b0;
        check("abort_start_pulse", MultCtrl, 1);
        repeat (3) @(posedge clock);
        #1;
        check("abort_wait_cnt", wait_cnt, 2);
        check("abort_mux_before", HICtrl, 1);
        reset = 1'b0;
        #1;
        check("abort_outputs", {MultCtrl, DivCtrl, WriteHI, WriteLO, done, div_zero,
                                timeout, busy, HICtrl, LOCtrl}, 0);
        check("abort_wait_cnt_clr", wait_cnt, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        stray = 0;
        repeat (50) begin
            @(posedge clock); #1;
            stray += int'(WriteHI | WriteLO | done | MultCtrl | DivCtrl | busy);
        end
        check("abort_no_followup", stray, 0);

        // Directed cases, then boundaries, then random traffic.
        runOp(2'b00, $urandom, 33, 1'b0);
        runOp(2'b01, 32'h0000_0007, 32, 1'b1);
        runOp(2'b01, 32'h0000_0000, 5, 1'b0);
        runOp(2'b00, $urandom, TIMEOUT + 5, 1'b0);
        runOp(2'b00, $urandom, 6, 1'b1);
        runOp(2'b11, $urandom, 3, 1'b0);
        runOp(2'b10, 32'h0000_0000, 3, 1'b0);
        runOp(2'b01, 32'h8000_0000, 1, 1'b1);
        runOp(2'b00, $urandom, TIMEOUT, 1'b1);
        runOp(2'b01, 32'h0000_0001, TIMEOUT + 1, 1'b1);
        for (int i = 0; i < 60; i++) begin
            runOp(2'($urandom), ($urandom % 4 == 0) ? 32'd0 : $urandom,
                  $urandom_range(1, TIMEOUT + 3), 1'($urandom % 2));
        end

        begin
            int n = 0;
            while (expQ.size() != 0 && n < 200) begin
                @(posedge clock); #1;
                n++;
            end
            if (expQ.size() != 0) begin
                total++; bad++;
                $display("FAIL drain: got %0d pending expected 0", expQ.size());
            end
        end
        repeat (2) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
